// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - opcode in / control out bundle between main-control FSM and datapath
interface mc_control_fsm_if #(
    parameter int OPW = 6,
    parameter int STW = 4
);
    logic [OPW-1:0] opcode;
    logic           PCWrite;
    logic           PCWriteCond;
    logic           IorD;
    logic           MemRead;
    logic           MemWrite;
    logic           IRWrite;
    logic           MemtoReg;
    logic           RegDst;
    logic           RegWrite;
    logic           ALUSrcA;
    logic [1:0]     ALUSrcB;
    logic [1:0]     ALUOp;
    logic [1:0]     PCSource;
    logic           illegal_op;
    logic [STW-1:0] state_out;

    // controller side: decodes opcode, drives every datapath control
    modport master (
        input  opcode,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
        output MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
        output illegal_op, state_out
    );

    // datapath side: supplies IR[31:26], consumes the controls
    modport slave (
        output opcode,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
        input  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
        input  illegal_op, state_out
    );
endinterface

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - Moore main-control FSM for the multi-cycle MIPS datapath
module mc_control_fsm #(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic               clk,
    input  logic               reset,
    mc_control_fsm_if.master   bus
);

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;

    typedef enum logic [STW-1:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    state_t state;
    ctrl_t  ctrl;
    logic   illegal_q;

    function automatic logic is_supported(input logic [OPW-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

    function automatic state_t next_state(input state_t s, input logic [OPW-1:0] op);
        state_t n;
        n = S_FETCH;
        case (s)
            S_RST:    n = S_FETCH;
            S_FETCH:  n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     n = S_EXEC;
                    OP_LW, OP_SW: n = S_MEMADR;
                    OP_BEQ:       n = S_BRANCH;
                    OP_ADDI:      n = S_ADDIEX;
                    OP_J:         n = S_JUMP;
                    default:      n = S_FETCH;
                endcase
            end
            // anything that is not lw here is treated as sw
            S_MEMADR: n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  n = S_MEMWB;
            S_EXEC:   n = S_ALUWB;
            S_ADDIEX: n = S_ADDIWB;
            default:  n = S_FETCH;
        endcase
        return n;
    endfunction

    // control word asserted while sitting in state s; unlisted fields stay 0
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // state advance; the control word is registered from the next state so it
    // is a function of the state register alone and stable for the whole cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_RST;
            ctrl      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= next_state(state, bus.opcode);
            ctrl      <= ctrl_for(next_state(state, bus.opcode));
            illegal_q <= (state == S_DECODE) && !is_supported(bus.opcode);
        end
    end

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.illegal_op  = illegal_q;
    assign bus.state_out   = state;

endmodule
